stream_seq_checker: RTL and testbench

- Receive-side companion to the massive-send traffic generator.
- Sits on the user recv stream of `ftdi_245fifo`, which is AXI-stream-master-like: `otvalid`/`otready`/`otdata` in the `oclk` domain.
- Consumes host-originated words, checks that they form a wrapping incrementing sequence, and keeps word/error statistics for LEDs or a debug bus.
- Used in the "massive receive" demo and for throughput/integrity soak tests of the FT232H/FT600 link.

---
 rtl/stream_seq_checker.sv | 102 ++++++++++
 tb/tb_stream_seq_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_seq_checker.sv
// Receive-side sequence checker for the ftdi_245fifo recv stream: verifies a wrapping
// incrementing word sequence and keeps saturating statistics. Optional macro: STREAM_SEQ_CHECKER_BACKPRESSURE_EN.
module stream_seq_checker #(
    parameter int DSIZE     = 1,
    parameter int CNT_WIDTH = 32,
    parameter int ERR_LIMIT = 4
) (
    input  logic                   oclk,
    input  logic                   rst,
    input  logic                   otvalid,
    output logic                   otready,
    input  logic [DSIZE*8-1:0]     otdata,
    input  logic                   clear,
    output logic                   locked,
    output logic [CNT_WIDTH-1:0]   word_cnt,
    output logic [CNT_WIDTH-1:0]   err_cnt,
    output logic                   err_flag,
    output logic [DSIZE*8-1:0]     last_bad
);

    localparam int DW = DSIZE * 8;
    localparam int MW = $clog2(ERR_LIMIT + 1);

    localparam logic ST_UNLOCKED = 1'b0;
    localparam logic ST_LOCKED   = 1'b1;

    logic          state;
    logic [DW-1:0] expected;
    logic [MW-1:0] miss;
    logic [MW-1:0] miss_inc;
    logic          hs;

    assign hs       = otvalid & otready;
    assign miss_inc = miss + 1'b1;
    assign locked   = (state == ST_LOCKED);

`ifdef STREAM_SEQ_CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; otready takes the pre-shift bits for ~75% duty.
    always_ff @(posedge oclk or posedge rst) begin
        if (rst) begin
            lfsr    <= 16'hACE1;
            otready <= 1'b0;
        end else begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            otready <= lfsr[0] | lfsr[1];
        end
    end
`else
    always_ff @(posedge oclk or posedge rst) begin
        if (rst) begin
            otready <= 1'b0;
        end else begin
            otready <= 1'b1;
        end
    end
`endif

    always_ff @(posedge oclk or posedge rst) begin
        if (rst) begin
            state    <= ST_UNLOCKED;
            expected <= '0;
            miss     <= '0;
            word_cnt <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            last_bad <= '0;
        end else if (clear) begin
            // a handshake coinciding with clear is consumed but deliberately ignored
            state    <= ST_UNLOCKED;
            miss     <= '0;
            word_cnt <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
            last_bad <= '0;
        end else if (hs) begin
            if (word_cnt != '1) begin
                word_cnt <= word_cnt + 1'b1;
            end
            expected <= otdata + 1'b1;
            if (state == ST_UNLOCKED) begin
                state <= ST_LOCKED;
            end else if (otdata == expected) begin
                miss <= '0;
            end else begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                err_flag <= 1'b1;
                last_bad <= otdata;
                if (miss_inc == MW'(ERR_LIMIT)) begin
                    state <= ST_UNLOCKED;
                    miss  <= '0;
                end else begin
                    miss <= miss_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_seq_checker.sv
// Directed self-checking bench for stream_seq_checker: default instance plus a CNT_WIDTH=4 instance.
module tb_stream_seq_checker;

    logic        oclk = 1'b0;
    logic        rst;
    logic        otvalid;
    logic [7:0]  otdata;
    logic        clear;

    logic        otready;
    logic        locked;
    logic [31:0] word_cnt;
    logic [31:0] err_cnt;
    logic        err_flag;
    logic [7:0]  last_bad;

    logic        s_otready;
    logic        s_locked;
    logic [3:0]  s_word_cnt;
    logic [3:0]  s_err_cnt;
    logic        s_err_flag;
    logic [7:0]  s_last_bad;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 oclk = ~oclk;

    stream_seq_checker #(.DSIZE(1), .CNT_WIDTH(32), .ERR_LIMIT(4)) dut (
        .oclk(oclk), .rst(rst), .otvalid(otvalid), .otready(otready), .otdata(otdata),
        .clear(clear), .locked(locked), .word_cnt(word_cnt), .err_cnt(err_cnt),
        .err_flag(err_flag), .last_bad(last_bad)
    );

    stream_seq_checker #(.DSIZE(1), .CNT_WIDTH(4), .ERR_LIMIT(4)) dut_sat (
        .oclk(oclk), .rst(rst), .otvalid(otvalid), .otready(s_otready), .otdata(otdata),
        .clear(clear), .locked(s_locked), .word_cnt(s_word_cnt), .err_cnt(s_err_cnt),
        .err_flag(s_err_flag), .last_bad(s_last_bad)
    );

    task automatic send_word(input logic [7:0] d);
        @(negedge oclk);
        otvalid = 1'b1;
        otdata  = d;
    endtask

    task automatic idle();
        @(negedge oclk);
        otvalid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge oclk);
        otvalid = 1'b0;
        clear   = 1'b1;
        @(negedge oclk);
        clear   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; otvalid = 1'b0; otdata = '0; clear = 1'b0;
        repeat (3) @(negedge oclk);
        n_checks++; if (otready !== 1'b0) begin n_fail++; $display("FAIL reset_otready: got %b expected 0", otready); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_checks++; if (word_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
        n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_err_flag: got %b expected 0", err_flag); end
        n_checks++; if (last_bad !== 8'd0) begin n_fail++; $display("FAIL reset_last_bad: got %0d expected 0", last_bad); end
        rst = 1'b0;
        @(negedge oclk);
        n_checks++; if (otready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", otready); end
    endtask

    task automatic test_clean_ramp();
        send_word(8'd0);
        idle();
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL ramp_lock_first: got %b expected 1", locked); end
        for (int i = 1; i < 260; i++) send_word(8'(i));
        idle();
        n_checks++; if (word_cnt !== 32'd260) begin n_fail++; $display("FAIL ramp_word_cnt: got %0d expected 260", word_cnt); end
        n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL ramp_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL ramp_err_flag: got %b expected 0", err_flag); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL ramp_locked: got %b expected 1", locked); end
    endtask

    task automatic test_single_glitch();
        logic [7:0] v [6] = '{8'd10, 8'd11, 8'd12, 8'd40, 8'd41, 8'd42};
        do_clear();
        foreach (v[i]) send_word(v[i]);
        idle();
        n_checks++; if (err_cnt !== 32'd1) begin n_fail++; $display("FAIL glitch_err_cnt: got %0d expected 1", err_cnt); end
        n_checks++; if (last_bad !== 8'd40) begin n_fail++; $display("FAIL glitch_last_bad: got %0d expected 40", last_bad); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL glitch_locked: got %b expected 1", locked); end
        n_checks++; if (word_cnt !== 32'd6) begin n_fail++; $display("FAIL glitch_word_cnt: got %0d expected 6", word_cnt); end
        n_checks++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL glitch_err_flag: got %b expected 1", err_flag); end
    endtask

    task automatic test_loss_of_lock();
        do_clear();
        send_word(8'd5); send_word(8'd9); send_word(8'd20); send_word(8'd31);
        idle();
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lol_still_locked: got %b expected 1", locked); end
        n_checks++; if (err_cnt !== 32'd3) begin n_fail++; $display("FAIL lol_err3: got %0d expected 3", err_cnt); end
        send_word(8'd42);
        idle();
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lol_unlocked: got %b expected 0", locked); end
        n_checks++; if (err_cnt !== 32'd4) begin n_fail++; $display("FAIL lol_err4: got %0d expected 4", err_cnt); end
        n_checks++; if (last_bad !== 8'd42) begin n_fail++; $display("FAIL lol_last_bad: got %0d expected 42", last_bad); end
        send_word(8'd43); send_word(8'd44);
        idle();
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lol_relock: got %b expected 1", locked); end
        n_checks++; if (err_cnt !== 32'd4) begin n_fail++; $display("FAIL lol_err_after_relock: got %0d expected 4", err_cnt); end
        n_checks++; if (word_cnt !== 32'd7) begin n_fail++; $display("FAIL lol_word_cnt: got %0d expected 7", word_cnt); end
    endtask

    task automatic test_clear_collision();
        @(negedge oclk);
        clear = 1'b1; otvalid = 1'b1; otdata = 8'h55;
        @(negedge oclk);
        clear = 1'b0;
        n_checks++; if (word_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_word_cnt: got %0d expected 0", word_cnt); end
        n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL clr_err_flag: got %b expected 0", err_flag); end
        n_checks++; if (last_bad !== 8'd0) begin n_fail++; $display("FAIL clr_last_bad: got %0d expected 0", last_bad); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL clr_locked: got %b expected 0", locked); end
        otdata = 8'h56;
        send_word(8'h57);
        idle();
        n_checks++; if (word_cnt !== 32'd2) begin n_fail++; $display("FAIL clr_after_word_cnt: got %0d expected 2", word_cnt); end
        n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_after_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL clr_after_locked: got %b expected 1", locked); end
    endtask

    task automatic test_gapped_valid();
        do_clear();
        send_word(8'd100); idle();
        send_word(8'd101); idle(); idle();
        send_word(8'd102); idle();
        n_checks++; if (word_cnt !== 32'd3) begin n_fail++; $display("FAIL gap_word_cnt: got %0d expected 3", word_cnt); end
        n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL gap_err_cnt: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int i = 0; i < 20; i++) send_word(8'(i));
        idle();
        n_checks++; if (s_word_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_word_cnt: got %0d expected 15", s_word_cnt); end
        n_checks++; if (s_err_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_err_cnt_clean: got %0d expected 0", s_err_cnt); end
        // every word jumps by 2; each 5th word relocks after 4 misses, so 16 errors in 20 words
        for (int i = 0; i < 20; i++) send_word(8'(100 + 2 * i));
        idle();
        n_checks++; if (s_err_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_err_cnt: got %0d expected 15", s_err_cnt); end
        n_checks++; if (s_word_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_word_cnt_hold: got %0d expected 15", s_word_cnt); end
        n_checks++; if (err_cnt !== 32'd16) begin n_fail++; $display("FAIL sat_wide_err_cnt: got %0d expected 16", err_cnt); end
        n_checks++; if (word_cnt !== 32'd40) begin n_fail++; $display("FAIL sat_wide_word_cnt: got %0d expected 40", word_cnt); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_locked: got %b expected 1", locked); end
    endtask

    task automatic test_midop_reset();
        send_word(8'd200); send_word(8'd201);
        @(negedge oclk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (word_cnt !== 32'd0) begin n_fail++; $display("FAIL async_rst_word_cnt: got %0d expected 0", word_cnt); end
        n_checks++; if (otready !== 1'b0) begin n_fail++; $display("FAIL async_rst_otready: got %b expected 0", otready); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL async_rst_locked: got %b expected 0", locked); end
        @(negedge oclk);
        rst = 1'b0; otvalid = 1'b0;
        @(negedge oclk);
        send_word(8'd7); send_word(8'd8);
        idle();
        n_checks++; if (locked !== 1'b1 || word_cnt !== 32'd2 || err_cnt !== 32'd0) begin
            n_fail++; $display("FAIL relock_after_rst: got locked=%b words=%0d errs=%0d expected 1/2/0", locked, word_cnt, err_cnt);
        end
    endtask

    task automatic test_backpressure();
        int         hs_cnt;
        logic       last_r;
        do_clear();
        otvalid = 1'b1;
        otdata  = 8'd0;
        last_r  = otready;
        hs_cnt  = int'(otready);
        for (int i = 1; i < 1000; i++) begin
            @(negedge oclk);
            if (last_r) otdata = otdata + 8'd1;
            last_r = otready;
            hs_cnt += int'(otready);
        end
        idle();
        n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL bp_err_cnt: got %0d expected 0", err_cnt); end
        n_checks++; if (word_cnt !== 32'(hs_cnt)) begin n_fail++; $display("FAIL bp_word_cnt: got %0d expected %0d", word_cnt, hs_cnt); end
`ifndef STREAM_SEQ_CHECKER_BACKPRESSURE_EN
        n_checks++; if (hs_cnt != 1000) begin n_fail++; $display("FAIL bp_ready_constant: got %0d ready cycles expected 1000", hs_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_clean_ramp();
        test_single_glitch();
        test_loss_of_lock();
        test_clear_collision();
        test_gapped_valid();
        test_saturation();
        test_midop_reset();
        test_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
